serv_rf_ram_arb: RTL and testbench

Shares one register-file RAM between the core's serial RF RAM interface and a 32-bit host port (debug module or boot loader). Core read/write burst requests are captured, arbitrated round-robin against host register accesses, and forwarded as single-cycle pulses to the RF RAM interface. The RAM port is muxed to the current owner. Host accesses are sequenced as `32/width` RAM beats.

---
 rtl/serv_rf_arb_pkg.sv | 30 +++
 rtl/serv_rf_arb_host.sv | 113 +++++++++++
 rtl/serv_rf_ram_arb.sv | 168 ++++++++++++++++
 tb/tb_serv_rf_ram_arb.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/serv_rf_arb_pkg.sv
// serv_rf_arb_pkg: arbiter state encodings and width helpers
// shared by serv_rf_ram_arb and serv_rf_arb_host.
package serv_rf_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CORE = 2'd1,
    ST_HRD  = 2'd2,
    ST_HWR  = 2'd3
  } arb_st_e;

  // RAM beats per 32-bit host register
  function automatic int beats(input int width);
    return 32 / width;
  endfunction

  function automatic int rw_of(input int csr_regs);
    return $clog2(32 + csr_regs);
  endfunction

  function automatic int aw_of(input int depth);
    return $clog2(depth);
  endfunction

  // bits needed to hold the values 0..n
  function automatic int cbits(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/serv_rf_arb_host.sv
// serv_rf_arb_host: host beat sequencer. Loads the register
// index (and write data) on grant, walks W=32/width RAM beats,
// assembles read data and pulses o_hack on completion.
// Ports: i_grant loads operands, i_act/i_wr give the host state,
// o_addr/o_wdata/o_wen drive the RAM, o_done ends the state,
// o_hack/o_hrdata go to the host.
// Host writes exist only with SERV_RF_ARB_HOST_WR_EN defined.
module serv_rf_arb_host
  import serv_rf_arb_pkg::*;
#(
  parameter int width = 8,
  parameter int rw    = 6,
  parameter int aw    = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_grant,
  input  logic             i_act,
  input  logic             i_wr,
  input  logic [rw-1:0]    i_hreg,
  input  logic [31:0]      i_hwdata,
  input  logic [width-1:0] i_rdata,
  output logic [aw-1:0]    o_addr,
  output logic [width-1:0] o_wdata,
  output logic             o_wen,
  output logic             o_done,
  output logic             o_hack,
  output logic [31:0]      o_hrdata
);

  localparam int W  = beats(width);
  localparam int BW = cbits(W);

  logic [rw-1:0] r_hreg;
  logic [BW-1:0] r_b;
  logic [31:0]   r_rbuf;
  logic [31:0]   w_rnext;
  logic          w_cap;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_hreg   <= '0;
      r_b      <= '0;
      r_rbuf   <= '0;
      o_hack   <= 1'b0;
      o_hrdata <= '0;
    end else begin
      o_hack <= o_done;
      if (i_grant) begin
        r_hreg <= i_hreg;
        r_b    <= '0;
      end else if (i_act) begin
        r_b <= r_b + BW'(1);
      end
      if (w_cap) r_rbuf <= w_rnext;
      // publish only complete words
      if (o_done && !i_wr) o_hrdata <= w_rnext;
    end
  end

  generate
    if (W == 1) begin : g_a1
      assign o_addr = aw'(r_hreg);
    end else begin : g_an
      localparam int SB = $clog2(W);
      assign o_addr = aw'({r_hreg, r_b[SB-1:0]});
    end
  endgenerate

  // reads need one extra cycle: data of beat b lands at b+1
  always_comb begin
    o_done = 1'b0;
    if (i_act) begin
      o_done = i_wr ? (r_b == BW'(W - 1))
                    : (r_b == BW'(W));
    end
  end

  assign w_cap = i_act && !i_wr && (r_b != '0);

  always_comb begin
    w_rnext = r_rbuf;
    for (int k = 0; k < W; k++) begin
      if (r_b == BW'(k + 1))
        w_rnext[k*width +: width] = i_rdata;
    end
  end

`ifdef SERV_RF_ARB_HOST_WR_EN
  logic [31:0] r_wdata;

  always_ff @(posedge i_clk) begin
    if (i_rst) r_wdata <= '0;
    else if (i_grant) r_wdata <= i_hwdata;
  end

  always_comb begin
    o_wdata = '0;
    for (int k = 0; k < W; k++) begin
      if (r_b == BW'(k))
        o_wdata = r_wdata[k*width +: width];
    end
  end

  assign o_wen = i_act && i_wr;
`else
  logic w_unused;
  assign w_unused = &{1'b0, i_hwdata};
  assign o_wdata  = '0;
  assign o_wen    = 1'b0;
`endif

endmodule

// File: rtl/serv_rf_ram_arb.sv
// serv_rf_ram_arb: shares the RF RAM between the serial core
// interface and a 32-bit host port, round-robin arbitrated.
// Ports: i_rreq/i_wreq -> o_rreq/o_wreq forwarded pulses,
// i_c_* core RAM side, o_* RAM side, i_rdata RAM read data,
// i_hreq/i_hwe/i_hreg/i_hwdata host request, o_hack/o_hrdata.
// Host writes exist only with SERV_RF_ARB_HOST_WR_EN defined.
module serv_rf_ram_arb
  import serv_rf_arb_pkg::*;
#(
  parameter int width    = 8,
  parameter int csr_regs = 4,
  parameter int depth    = 32*(32+csr_regs)/width,
  parameter int core_win = 36,
  localparam int rw = rw_of(csr_regs),
  localparam int aw = aw_of(depth)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_rreq,
  input  logic             i_wreq,
  output logic             o_rreq,
  output logic             o_wreq,
  input  logic [aw-1:0]    i_c_waddr,
  input  logic [width-1:0] i_c_wdata,
  input  logic             i_c_wen,
  input  logic [aw-1:0]    i_c_raddr,
  output logic [aw-1:0]    o_waddr,
  output logic [width-1:0] o_wdata,
  output logic             o_wen,
  output logic [aw-1:0]    o_raddr,
  input  logic [width-1:0] i_rdata,
  input  logic             i_hreq,
  input  logic             i_hwe,
  input  logic [rw-1:0]    i_hreg,
  input  logic [31:0]      i_hwdata,
  output logic             o_hack,
  output logic [31:0]      o_hrdata
);

  localparam int CW = cbits(core_win - 1);

  arb_st_e r_state;
  arb_st_e w_state_n;

  logic          r_rp;
  logic          r_wp;
  logic          r_last_host;
  logic [CW-1:0] r_cnt;

  logic w_rp;
  logic w_wp;
  logic w_cpend;
  logic w_hpend;
  logic w_hwe;
  logic w_cgrant;
  logic w_hgrant;
  logic w_fwd;
  logic w_host;
  logic w_hwr;

  logic [aw-1:0]    w_h_addr;
  logic [width-1:0] w_h_wdata;
  logic             w_h_wen;
  logic             w_h_done;

`ifdef SERV_RF_ARB_HOST_WR_EN
  assign w_hwe = i_hwe;
`else
  logic w_unused;
  assign w_unused = &{1'b0, i_hwe};
  assign w_hwe    = 1'b0;
`endif

  // a pulse arriving this cycle counts as pending already
  assign w_rp    = r_rp | i_rreq;
  assign w_wp    = r_wp | i_wreq;
  assign w_cpend = w_rp | w_wp;
  // the host still holds i_hreq in its ack cycle
  assign w_hpend = i_hreq & ~o_hack;

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= ST_IDLE;
    else r_state <= w_state_n;
  end

  always_comb begin
    w_state_n = r_state;
    w_cgrant  = 1'b0;
    w_hgrant  = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_cpend && (!w_hpend || r_last_host)) begin
          w_cgrant  = 1'b1;
          w_state_n = ST_CORE;
        end else if (w_hpend) begin
          w_hgrant  = 1'b1;
          w_state_n = w_hwe ? ST_HWR : ST_HRD;
        end
      end
      ST_CORE: begin
        if (!w_cpend && (r_cnt == '0))
          w_state_n = ST_IDLE;
      end
      ST_HRD, ST_HWR: begin
        if (w_h_done) w_state_n = ST_IDLE;
      end
      default: w_state_n = ST_IDLE;
    endcase
  end

  always_comb begin
    w_host  = (r_state == ST_HRD) || (r_state == ST_HWR);
    w_hwr   = (r_state == ST_HWR);
    w_fwd   = w_cgrant || (r_state == ST_CORE);
    o_waddr = i_c_waddr;
    o_raddr = i_c_raddr;
    o_wdata = i_c_wdata;
    o_wen   = i_c_wen;
    if (w_host) begin
      o_waddr = w_h_addr;
      o_raddr = w_h_addr;
      o_wdata = w_h_wdata;
      o_wen   = w_h_wen;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rp        <= 1'b0;
      r_wp        <= 1'b0;
      r_cnt       <= '0;
      r_last_host <= 1'b1;
      o_rreq      <= 1'b0;
      o_wreq      <= 1'b0;
    end else begin
      o_rreq <= w_fwd & w_rp;
      o_wreq <= w_fwd & w_wp;
      r_rp   <= ~w_fwd & w_rp;
      r_wp   <= ~w_fwd & w_wp;
      if (w_fwd && w_cpend) r_cnt <= CW'(core_win - 1);
      else if (r_cnt != '0) r_cnt <= r_cnt - CW'(1);
      if (w_cgrant) r_last_host <= 1'b0;
      else if (w_hgrant) r_last_host <= 1'b1;
    end
  end

  serv_rf_arb_host #(
    .width (width),
    .rw    (rw),
    .aw    (aw)
  ) u_host (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_grant  (w_hgrant),
    .i_act    (w_host),
    .i_wr     (w_hwr),
    .i_hreg   (i_hreg),
    .i_hwdata (i_hwdata),
    .i_rdata  (i_rdata),
    .o_addr   (w_h_addr),
    .o_wdata  (w_h_wdata),
    .o_wen    (w_h_wen),
    .o_done   (w_h_done),
    .o_hack   (o_hack),
    .o_hrdata (o_hrdata)
  );

endmodule

// File: tb/tb_serv_rf_ram_arb.sv
// tb_serv_rf_ram_arb: scoreboard bench for serv_rf_ram_arb
// with a behavioural RF RAM behind the muxed port.
module tb_serv_rf_ram_arb;

  localparam int WD  = 8;
  localparam int CSR = 4;
  localparam int DEP = 32*(32+CSR)/WD;
  localparam int RW  = $clog2(32+CSR);
  localparam int AW  = $clog2(DEP);
  localparam int NB  = 32/WD;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rreq = 0, wreq = 0;
  logic o_rreq, o_wreq;
  logic [AW-1:0] c_waddr = '0, c_raddr = '0;
  logic [WD-1:0] c_wdata = '0;
  logic c_wen = 1'b0;
  logic [AW-1:0] o_waddr, o_raddr;
  logic [WD-1:0] o_wdata;
  logic o_wen;
  logic [WD-1:0] rdata = '0;
  logic hreq = 0, hwe = 0;
  logic [RW-1:0] hreg = '0;
  logic [31:0] hwdata = '0;
  logic o_hack;
  logic [31:0] o_hrdata;

  always #5 clk = ~clk;

  serv_rf_ram_arb dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_rreq    (rreq),
    .i_wreq    (wreq),
    .o_rreq    (o_rreq),
    .o_wreq    (o_wreq),
    .i_c_waddr (c_waddr),
    .i_c_wdata (c_wdata),
    .i_c_wen   (c_wen),
    .i_c_raddr (c_raddr),
    .o_waddr   (o_waddr),
    .o_wdata   (o_wdata),
    .o_wen     (o_wen),
    .o_raddr   (o_raddr),
    .i_rdata   (rdata),
    .i_hreq    (hreq),
    .i_hwe     (hwe),
    .i_hreg    (hreg),
    .i_hwdata  (hwdata),
    .o_hack    (o_hack),
    .o_hrdata  (o_hrdata)
  );

  logic [WD-1:0] mem [1<<AW];
  always @(posedge clk) begin
    if (o_wen) mem[o_waddr] <= o_wdata;
    rdata <= mem[o_raddr];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_bad = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  typedef struct {
    int          cyc;
    logic [31:0] data;
    bit          rd;
  } hack_t;

  typedef struct {
    int            cyc;
    logic [AW-1:0] addr;
    logic [WD-1:0] data;
  } wbeat_t;

  int     q_rreq[$];
  int     q_wreq[$];
  hack_t  q_hack[$];
  wbeat_t q_wr[$];

  int     m_e;
  hack_t  m_h;
  wbeat_t m_w;

  always @(negedge clk) begin
    if (!rst) begin
      if (o_rreq) begin
        m_e = (q_rreq.size() > 0) ? q_rreq.pop_front() : -1;
        chk("rreq_cyc", cyc, m_e);
      end
      if (o_wreq) begin
        m_e = (q_wreq.size() > 0) ? q_wreq.pop_front() : -1;
        chk("wreq_cyc", cyc, m_e);
      end
      if (o_hack) begin
        if (q_hack.size() > 0) m_h = q_hack.pop_front();
        else m_h = '{cyc: -1, data: 32'h0, rd: 1'b0};
        chk("hack_cyc", cyc, m_h.cyc);
        if (m_h.rd) chk("hrdata", o_hrdata, m_h.data);
      end
      if (o_wen && !c_wen) begin
        if (q_wr.size() > 0) m_w = q_wr.pop_front();
        else m_w = '{cyc: -1, addr: '0, data: '0};
        chk("hwr_cyc", cyc, m_w.cyc);
        chk("hwr_addr", o_waddr, m_w.addr);
        chk("hwr_data", o_wdata, m_w.data);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic core_write(input int r, input logic [31:0] d);
    for (int b = 0; b < NB; b++) begin
      tick();
      c_waddr = AW'(r*NB + b);
      c_wdata = d[b*WD +: WD];
      c_wen   = 1'b1;
      if (b == 0) begin
        @(negedge clk);
        chk("core_mux_wen", o_wen, 1);
        chk("core_mux_waddr", o_waddr, c_waddr);
      end
    end
    tick();
    c_wen = 1'b0;
  endtask

  task automatic wait_hack(input string tag);
    bit seen = 0;
    for (int n = 0; n < 120 && !seen; n++) begin
      tick();
      seen = o_hack;
    end
    chk(tag, seen, 1);
    hreq = 1'b0;
  endtask

  int t;
  logic [31:0] exp5;

  initial begin
`ifdef SERV_RF_ARB_HOST_WR_EN
    exp5 = 32'hDEADBEEF;
`else
    exp5 = 32'hCAFEF00D;
`endif
    repeat (3) tick();
    @(negedge clk);
    chk("rst_rreq", o_rreq, 0);
    chk("rst_wreq", o_wreq, 0);
    chk("rst_hack", o_hack, 0);
    chk("rst_wen", o_wen, 0);
    chk("rst_hrdata", o_hrdata, 0);
    tick();
    rst = 1'b0;

    core_write(7, 32'h12345678);
    core_write(5, 32'hCAFEF00D);

    // core and host together after reset: core first
    tick();
    t = cyc;
    rreq = 1; hreq = 1; hwe = 0; hreg = RW'(7);
    q_rreq.push_back(t + 1);
    q_hack.push_back('{cyc: t + 43, data: 32'h12345678, rd: 1'b1});
    tick();
    rreq = 0;
    c_raddr = AW'(11);
    @(negedge clk);
    chk("win_first_raddr", o_raddr, 11);
    while (cyc < t + 36) begin
      tick();
      c_raddr = AW'(cyc);
    end
    @(negedge clk);
    chk("win_last_raddr", o_raddr, c_raddr);
    tick();
    c_raddr = AW'(99);
    @(negedge clk);
    chk("idle_raddr", o_raddr, 99);
    tick();
    @(negedge clk);
    chk("host_raddr", o_raddr, 28);
    chk("host_rd_wen", o_wen, 0);
    wait_hack("C_hack_seen");

    // host write (read only when writes are compiled out)
    tick();
    t = cyc;
    hreq = 1; hwe = 1; hreg = RW'(5); hwdata = 32'hDEADBEEF;
`ifdef SERV_RF_ARB_HOST_WR_EN
    for (int b = 0; b < NB; b++) begin
      logic [31:0] dd;
      dd = 32'hDEADBEEF;
      q_wr.push_back('{cyc: t + 1 + b, addr: AW'(20 + b),
                       data: dd[b*WD +: WD]});
    end
    q_hack.push_back('{cyc: t + 5, data: 32'h0, rd: 1'b0});
`else
    q_hack.push_back('{cyc: t + 6, data: 32'hCAFEF00D, rd: 1'b1});
`endif
    wait_hack("D_hack_seen");
    hwe = 0;

    // host read with a core write request landing mid-burst
    tick();
    t = cyc;
    hreq = 1; hreg = RW'(5);
    q_hack.push_back('{cyc: t + 6, data: exp5, rd: 1'b1});
    tick();
    tick();
    wreq = 1;
    q_wreq.push_back(t + 7);
    tick();
    wreq = 0;
    c_wen = 1; c_waddr = AW'(3); c_wdata = 8'h55;
    @(negedge clk);
    chk("blk_c_wen", o_wen, 0);
    tick();
    c_wen = 0;
    wait_hack("E_hack_seen");

    // last grant was core: host wins the next tie
    repeat (40) tick();
    tick();
    t = cyc;
    rreq = 1; hreq = 1; hwe = 0; hreg = RW'(7);
    q_hack.push_back('{cyc: t + 6, data: 32'h12345678, rd: 1'b1});
    q_rreq.push_back(t + 7);
    tick();
    rreq = 0;
    wait_hack("F_hack_seen");

    // reset in the middle of a host read
    repeat (40) tick();
    tick();
    hreq = 1; hreg = RW'(7);
    tick();
    tick();
    rst = 1; hreq = 0;
    tick();
    rst = 0;
    @(negedge clk);
    chk("midrst_hrdata", o_hrdata, 0);

    // simultaneous read and write pulses
    tick();
    t = cyc;
    rreq = 1; wreq = 1;
    q_rreq.push_back(t + 1);
    q_wreq.push_back(t + 1);
    tick();
    rreq = 0; wreq = 0;
    repeat (50) tick();

    chk("left_rreq", q_rreq.size(), 0);
    chk("left_wreq", q_wreq.size(), 0);
    chk("left_hack", q_hack.size(), 0);
    chk("left_hwr", q_wr.size(), 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
